net_sync_ctrl: RTL and testbench
================================

# net_sync_ctrl

Sequences the once-per-frame exchange of game state between the two karts over the Ethernet link. On each frame start it snapshots the local player state and drives a two-word packet into the transmitter with a valid/ready handshake. It also parses 32-bit words from the receiver, validates them, and holds the opponent state that feeds `track_view`, `racer_view` and `forward_view`. It sits between the VGA timing/game logic and the `transmit`/`receive` Ethernet modules, all on `eth_refclk`.

## Interface
Parameters:
- `TIMEOUT_FRAMES`, default 30: frame starts without an accepted packet before the link is declared down.
- `RX_GAP_CYCLES`, default 64: maximum idle cycles between header and payload before the RX parser aborts.

Ports:
- `clk_in`  input  1  — `eth_refclk`; the only clock.
- `rst_in`  input  1  — synchronous, active-high reset.
- `frame_start_in`  input  1  — one-cycle pulse at the start of vertical blank.
- `player_x_in`  input  11  — local x.
- `player_y_in`  input  11  — local y.
- `direction_in`  input  9  — local heading in degrees, 0–359.
- `game_stat_in`  input  2  — local game status.
- `tx_valid_out`  output  1  — transmit word valid.
- `tx_ready_in`  input  1  — transmitter can accept a word.
- `tx_data_out`  output  32  — transmit word.
- `rx_axiov_in`  input  1  — received word valid, one cycle per word.
- `rx_axiod_in`  input  32  — received word.
- `opponent_x_out`  output  11
- `opponent_y_out`  output  11
- `opponent_dir_out`  output  9
- `opponent_stat_out`  output  2
- `link_up_out`  output  1  — valid opponent packet seen within the timeout window.

## Operation
Packet format:
- Header word: [31:24] = `MAGIC` (8'hA5), [23:16] = seq, [15:2] = 0, [1:0] = game_stat.
- Payload word: [31:21] = x, [20:10] = y, [9:1] = dir, [0] = parity.

TX state machine (IDLE → HDR → PAY → IDLE):
- IDLE: when `frame_start_in` is high, snapshot all player inputs and go to HDR.
- HDR: `tx_valid_out` = 1 with the header on `tx_data_out`. On a beat (valid & ready), go to PAY.
- PAY: present the payload word. On a beat, increment `tx_seq` (8-bit, 255 wraps to 0) and return to IDLE.
- `tx_data_out` holds stable while valid is high and ready is low.
- A `frame_start_in` pulse outside IDLE is ignored; that frame sends no packet.

RX state machine (WAIT_HDR → WAIT_PAY):
- WAIT_HDR: a valid word with [31:24] == `MAGIC` latches seq and stat, then moves to WAIT_PAY. Any other valid word is discarded.
- WAIT_PAY: the next valid word is the payload, whatever its content.
- Acceptance: a payload is accepted if parity passes (see Configuration) and seq ≠ `last_seq`. The first packet after reset is always accepted.
- On acceptance: update all four opponent outputs, `last_seq` and `link_up_out`, and clear the frame-timeout counter.
- Duplicate seq or a parity failure: discard the payload and return to WAIT_HDR.
- If `RX_GAP_CYCLES` cycles pass in WAIT_PAY with no valid word, return to WAIT_HDR.

Link timeout:
- Saturating counter, incremented on each `frame_start_in`.
- When it reaches `TIMEOUT_FRAMES`, `link_up_out` goes to 0. Opponent outputs keep their last values.
- Acceptance and a `frame_start_in` in the same cycle: acceptance wins and the counter clears to 0.

Reset:
- All outputs are 0; `tx_seq` = 0; both FSMs go to their idle states.
- Reset mid-packet drops the packet, and `tx_valid_out` falls on the next edge.

## Timing
- `tx_valid_out` rises on the edge after the `frame_start_in` cycle (1-cycle latency).
- The header is presented until the first ready beat; the payload is presented on the following cycle.
- With `tx_ready_in` held high, the packet takes exactly 2 cycles.
- Opponent outputs and `link_up_out` update on the edge after the accepting payload beat.
- Opponent outputs are registered with no combinational path from `rx_axiod_in`.
- TX and RX run independently, so a simultaneous TX beat and RX word are both handled.

## Configuration
`NET_SYNC_PARITY_EN`:
- Defined: TX sets bit 0 so the XOR of payload[31:0] is 0 (even parity), and RX rejects any payload whose XOR is nonzero.
- Undefined: TX drives bit 0 = 0 and RX ignores bit 0.

## Structure
- Package `net_sync_pkg` holds:
  - `MAGIC`;
  - header and payload field bit positions;
  - the `tx_state_t` and `rx_state_t` enums;
  - a packed struct `kart_state_t` (x, y, dir, stat).
- One sub-module, `net_sync_rx`, contains the RX parser, duplicate filter, gap counter and opponent registers. The TX FSM and link timeout stay in the top.

## Test plan
- **Basic TX:** after reset, pulse frame_start with x=191, y=191, dir=270, stat=1 and ready high → header 32'hA5000001, then payload {191,191,270,p}; next packet has seq 1.
- **Backpressure:** ready low for 5 cycles during HDR → header held unchanged for 5 cycles, then 1 payload cycle. A frame_start during PAY sends no extra packet.
- **RX accept:** drive header 32'hA5070002, then payload {320,320,90,p} → opponent = 320/320/90, stat 2, link_up 1 one cycle later. Repeating the same seq 7 leaves the outputs unchanged.
- **Parity (macro on):** flip payload bit 5 → packet rejected, outputs unchanged. With the macro off, the same packet is accepted.
- **Gap:** header, then 64 idle cycles, then payload → the payload is discarded as a non-magic word and the outputs are unchanged.
- **Timeout / seq wrap:** 30 frame_starts with no RX → link_up falls on the 30th. Then receive seq 255 followed by seq 0 → both accepted and link_up returns to 1.

Source files
------------

// File: rtl/net_sync_pkg.sv
// Shared packet layout, FSM state types and kart state record for the kart-to-kart link.
// Word packing helpers are used by the TX side of net_sync_ctrl.
package net_sync_pkg;

  localparam logic [7:0] MAGIC = 8'hA5;

  // Header word fields
  localparam int HDR_MAGIC_MSB = 31;
  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_SEQ_MSB   = 23;
  localparam int HDR_SEQ_LSB   = 16;
  localparam int HDR_STAT_MSB  = 1;
  localparam int HDR_STAT_LSB  = 0;

  // Payload word fields
  localparam int PAY_X_MSB   = 31;
  localparam int PAY_X_LSB   = 21;
  localparam int PAY_Y_MSB   = 20;
  localparam int PAY_Y_LSB   = 10;
  localparam int PAY_DIR_MSB = 9;
  localparam int PAY_DIR_LSB = 1;
  localparam int PAY_PAR_BIT = 0;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_HDR,
    TX_PAY
  } tx_state_t;

  typedef enum logic {
    RX_WAIT_HDR,
    RX_WAIT_PAY
  } rx_state_t;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [8:0]  dir;
    logic [1:0]  stat;
  } kart_state_t;

  function automatic logic [31:0] pack_header(input logic [7:0] seq, input logic [1:0] stat);
    logic [31:0] w;
    w = '0;
    w[HDR_MAGIC_MSB:HDR_MAGIC_LSB] = MAGIC;
    w[HDR_SEQ_MSB:HDR_SEQ_LSB]     = seq;
    w[HDR_STAT_MSB:HDR_STAT_LSB]   = stat;
    return w;
  endfunction

  // Bit that makes the whole payload word XOR to zero.
  function automatic logic payload_parity(input logic [10:0] x, input logic [10:0] y,
                                          input logic [8:0] dir);
    return ^{x, y, dir};
  endfunction

  function automatic logic [31:0] pack_payload(input logic [10:0] x, input logic [10:0] y,
                                               input logic [8:0] dir, input logic par);
    logic [31:0] w;
    w = '0;
    w[PAY_X_MSB:PAY_X_LSB]     = x;
    w[PAY_Y_MSB:PAY_Y_LSB]     = y;
    w[PAY_DIR_MSB:PAY_DIR_LSB] = dir;
    w[PAY_PAR_BIT]             = par;
    return w;
  endfunction

endpackage

// File: rtl/net_sync_rx.sv
// RX parser: header/payload pairing, gap abort, duplicate-seq filter and opponent registers.
// Payload parity is checked only when NET_SYNC_PARITY_EN is defined.
module net_sync_rx
  import net_sync_pkg::*;
#(
  parameter int RX_GAP_CYCLES = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rx_axiov_in,
  input  logic [31:0] rx_axiod_in,
  output logic        accept,
  output kart_state_t opponent
);

  localparam int GAP_W = $clog2(RX_GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RX_GAP_CYCLES - 1);

  rx_state_t        rx_state_reg, rx_state_next;
  logic [7:0]       hdr_seq_reg, hdr_seq_next;
  logic [1:0]       hdr_stat_reg, hdr_stat_next;
  logic [7:0]       last_seq_reg, last_seq_next;
  logic             seen_reg, seen_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  kart_state_t      opp_reg, opp_next;
  logic             parity_ok;

`ifdef NET_SYNC_PARITY_EN
  assign parity_ok = ~(^rx_axiod_in);
`else
  logic unused_parity_bit;
  assign unused_parity_bit = rx_axiod_in[PAY_PAR_BIT];
  assign parity_ok         = 1'b1;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_state_reg <= RX_WAIT_HDR;
      hdr_seq_reg  <= '0;
      hdr_stat_reg <= '0;
      last_seq_reg <= '0;
      seen_reg     <= 1'b0;
      gap_cnt_reg  <= '0;
      opp_reg      <= '0;
    end else begin
      rx_state_reg <= rx_state_next;
      hdr_seq_reg  <= hdr_seq_next;
      hdr_stat_reg <= hdr_stat_next;
      last_seq_reg <= last_seq_next;
      seen_reg     <= seen_next;
      gap_cnt_reg  <= gap_cnt_next;
      opp_reg      <= opp_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    hdr_seq_next  = hdr_seq_reg;
    hdr_stat_next = hdr_stat_reg;
    last_seq_next = last_seq_reg;
    seen_next     = seen_reg;
    gap_cnt_next  = gap_cnt_reg;
    opp_next      = opp_reg;
    accept        = 1'b0;
    case (rx_state_reg)
      RX_WAIT_HDR: begin
        if (rx_axiov_in && rx_axiod_in[HDR_MAGIC_MSB:HDR_MAGIC_LSB] == MAGIC) begin
          hdr_seq_next  = rx_axiod_in[HDR_SEQ_MSB:HDR_SEQ_LSB];
          hdr_stat_next = rx_axiod_in[HDR_STAT_MSB:HDR_STAT_LSB];
          gap_cnt_next  = '0;
          rx_state_next = RX_WAIT_PAY;
        end
      end
      RX_WAIT_PAY: begin
        if (rx_axiov_in) begin
          rx_state_next = RX_WAIT_HDR;
          // seen_reg lets the very first packet through even if its seq equals the reset last_seq.
          if (parity_ok && (!seen_reg || hdr_seq_reg != last_seq_reg)) begin
            accept        = 1'b1;
            opp_next.x    = rx_axiod_in[PAY_X_MSB:PAY_X_LSB];
            opp_next.y    = rx_axiod_in[PAY_Y_MSB:PAY_Y_LSB];
            opp_next.dir  = rx_axiod_in[PAY_DIR_MSB:PAY_DIR_LSB];
            opp_next.stat = hdr_stat_reg;
            last_seq_next = hdr_seq_reg;
            seen_next     = 1'b1;
          end
        end else if (gap_cnt_reg == GAP_LAST) begin
          rx_state_next = RX_WAIT_HDR;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      default: rx_state_next = RX_WAIT_HDR;
    endcase
  end

  assign opponent = opp_reg;

endmodule

// File: rtl/net_sync_ctrl.sv
// Per-frame kart state exchange: TX packet sequencer, link timeout and the RX parser instance.
// Define NET_SYNC_PARITY_EN to generate and check even parity on the payload word.
module net_sync_ctrl
  import net_sync_pkg::*;
#(
  parameter int TIMEOUT_FRAMES = 30,
  parameter int RX_GAP_CYCLES  = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_start_in,
  input  logic [10:0] player_x_in,
  input  logic [10:0] player_y_in,
  input  logic [8:0]  direction_in,
  input  logic [1:0]  game_stat_in,
  output logic        tx_valid_out,
  input  logic        tx_ready_in,
  output logic [31:0] tx_data_out,
  input  logic        rx_axiov_in,
  input  logic [31:0] rx_axiod_in,
  output logic [10:0] opponent_x_out,
  output logic [10:0] opponent_y_out,
  output logic [8:0]  opponent_dir_out,
  output logic [1:0]  opponent_stat_out,
  output logic        link_up_out
);

  localparam int TO_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_FRAMES);

  tx_state_t       tx_state_reg, tx_state_next;
  kart_state_t     snap_reg, snap_next;
  logic [7:0]      tx_seq_reg, tx_seq_next;
  logic [TO_W-1:0] timeout_cnt_reg, timeout_cnt_next, timeout_cnt_inc;
  logic            link_up_reg, link_up_next;
  logic            pay_parity;
  logic            accept;
  kart_state_t     opponent;

`ifdef NET_SYNC_PARITY_EN
  assign pay_parity = payload_parity(snap_reg.x, snap_reg.y, snap_reg.dir);
`else
  assign pay_parity = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_state_reg    <= TX_IDLE;
      snap_reg        <= '0;
      tx_seq_reg      <= '0;
      timeout_cnt_reg <= '0;
      link_up_reg     <= 1'b0;
    end else begin
      tx_state_reg    <= tx_state_next;
      snap_reg        <= snap_next;
      tx_seq_reg      <= tx_seq_next;
      timeout_cnt_reg <= timeout_cnt_next;
      link_up_reg     <= link_up_next;
    end
  end

  // Data is a function of registered state only, so it cannot change while stalled.
  always_comb begin
    tx_state_next = tx_state_reg;
    snap_next     = snap_reg;
    tx_seq_next   = tx_seq_reg;
    tx_valid_out  = 1'b0;
    tx_data_out   = '0;
    case (tx_state_reg)
      TX_IDLE: begin
        if (frame_start_in) begin
          snap_next.x    = player_x_in;
          snap_next.y    = player_y_in;
          snap_next.dir  = direction_in;
          snap_next.stat = game_stat_in;
          tx_state_next  = TX_HDR;
        end
      end
      TX_HDR: begin
        tx_valid_out = 1'b1;
        tx_data_out  = pack_header(tx_seq_reg, snap_reg.stat);
        if (tx_ready_in) begin
          tx_state_next = TX_PAY;
        end
      end
      TX_PAY: begin
        tx_valid_out = 1'b1;
        tx_data_out  = pack_payload(snap_reg.x, snap_reg.y, snap_reg.dir, pay_parity);
        if (tx_ready_in) begin
          tx_seq_next   = tx_seq_reg + 8'd1;
          tx_state_next = TX_IDLE;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // Acceptance outranks a coincident frame start.
  always_comb begin
    timeout_cnt_next = timeout_cnt_reg;
    link_up_next     = link_up_reg;
    timeout_cnt_inc  = timeout_cnt_reg + 1'b1;
    if (accept) begin
      timeout_cnt_next = '0;
      link_up_next     = 1'b1;
    end else if (frame_start_in && timeout_cnt_reg != TO_MAX) begin
      timeout_cnt_next = timeout_cnt_inc;
      if (timeout_cnt_inc == TO_MAX) begin
        link_up_next = 1'b0;
      end
    end
  end

  net_sync_rx #(
    .RX_GAP_CYCLES(RX_GAP_CYCLES)
  ) u_rx (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rx_axiov_in (rx_axiov_in),
    .rx_axiod_in (rx_axiod_in),
    .accept      (accept),
    .opponent    (opponent)
  );

  assign opponent_x_out    = opponent.x;
  assign opponent_y_out    = opponent.y;
  assign opponent_dir_out  = opponent.dir;
  assign opponent_stat_out = opponent.stat;
  assign link_up_out       = link_up_reg;

endmodule

// File: tb/tb_net_sync_ctrl.sv
// Bench for net_sync_ctrl: TX words checked through a scoreboard queue, RX via a vector table.
module tb_net_sync_ctrl;

  localparam int TIMEOUT_FRAMES = 30;
  localparam int RX_GAP_CYCLES  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [10:0] player_x = '0;
  logic [10:0] player_y = '0;
  logic [8:0]  direction = '0;
  logic [1:0]  game_stat = '0;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] tx_data;
  logic        rx_axiov = 1'b0;
  logic [31:0] rx_axiod = '0;
  logic [10:0] opp_x;
  logic [10:0] opp_y;
  logic [8:0]  opp_dir;
  logic [1:0]  opp_stat;
  logic        link_up;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  tb_seq = 8'd0;
  logic [31:0] tx_q[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  net_sync_ctrl #(
    .TIMEOUT_FRAMES(TIMEOUT_FRAMES),
    .RX_GAP_CYCLES (RX_GAP_CYCLES)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .frame_start_in   (frame_start),
    .player_x_in      (player_x),
    .player_y_in      (player_y),
    .direction_in     (direction),
    .game_stat_in     (game_stat),
    .tx_valid_out     (tx_valid),
    .tx_ready_in      (tx_ready),
    .tx_data_out      (tx_data),
    .rx_axiov_in      (rx_axiov),
    .rx_axiod_in      (rx_axiod),
    .opponent_x_out   (opp_x),
    .opponent_y_out   (opp_y),
    .opponent_dir_out (opp_dir),
    .opponent_stat_out(opp_stat),
    .link_up_out      (link_up)
  );

  function automatic logic [31:0] mkpay(input logic [10:0] x, input logic [10:0] y,
                                        input logic [8:0] dir);
    logic [31:0] w;
    w = {x, y, dir, 1'b0};
`ifdef NET_SYNC_PARITY_EN
    w[0] = ^w;
`endif
    return w;
  endfunction

  function automatic logic [31:0] mkhdr(input logic [7:0] seq, input logic [1:0] stat);
    return {8'hA5, seq, 14'd0, stat};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queues the two words the DUT should send for the frame about to be started.
  task automatic tx_expect(input logic [10:0] x, input logic [10:0] y,
                           input logic [8:0] dir, input logic [1:0] stat);
    player_x  = x;
    player_y  = y;
    direction = dir;
    game_stat = stat;
    tx_q.push_back(mkhdr(tb_seq, stat));
    tx_q.push_back(mkpay(x, y, dir));
    tb_seq = tb_seq + 8'd1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic rx_word(input logic [31:0] w);
    rx_axiov = 1'b1;
    rx_axiod = w;
    step();
    rx_axiov = 1'b0;
    rx_axiod = '0;
  endtask

  task automatic check_opp(input string name, input logic [10:0] x, input logic [10:0] y,
                           input logic [8:0] dir, input logic [1:0] stat, input logic link);
    check({name, ".x"}, 32'(opp_x), 32'(x));
    check({name, ".y"}, 32'(opp_y), 32'(y));
    check({name, ".dir"}, 32'(opp_dir), 32'(dir));
    check({name, ".stat"}, 32'(opp_stat), 32'(stat));
    check({name, ".link"}, 32'(link_up), 32'(link));
  endtask

  task automatic drain_tx();
    for (int i = 0; i < 50 && tx_q.size() != 0; i++) step();
    check("tx_drain", 32'(tx_q.size()), 32'd0);
  endtask

  // Scoreboard: every handshake beat must match the oldest queued word.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got %h required no beat", tx_data);
      end else begin
        mon_exp = tx_q.pop_front();
        check("tx_beat", tx_data, mon_exp);
        $display("tx beat data=%h", tx_data);
      end
    end
  end

  typedef struct {
    string       name;
    logic [31:0] hdr;
    logic [31:0] pay;
    logic [10:0] x;
    logic [10:0] y;
    logic [8:0]  dir;
    logic [1:0]  stat;
  } rx_vec_t;

  rx_vec_t vecs[7];

  initial begin
    vecs[0] = '{"rx_first_seq0", 32'hA5000001, mkpay(11'd11, 11'd22, 9'd33), 11'd11, 11'd22, 9'd33, 2'd1};
    vecs[1] = '{"rx_accept", 32'hA5070002, mkpay(11'd320, 11'd320, 9'd90), 11'd320, 11'd320, 9'd90, 2'd2};
    vecs[2] = '{"rx_dup_seq", 32'hA5070003, mkpay(11'd100, 11'd100, 9'd10), 11'd320, 11'd320, 9'd90, 2'd2};
    vecs[3] = '{"rx_no_magic", 32'h12345678, mkpay(11'd100, 11'd100, 9'd10), 11'd320, 11'd320, 9'd90, 2'd2};
    vecs[4] = '{"rx_seq8", 32'hA5080001, mkpay(11'd5, 11'd6, 9'd7), 11'd5, 11'd6, 9'd7, 2'd1};
`ifdef NET_SYNC_PARITY_EN
    vecs[5] = '{"rx_parity", 32'hA5090003, mkpay(11'd10, 11'd20, 9'd30) ^ 32'h20, 11'd5, 11'd6, 9'd7, 2'd1};
`else
    vecs[5] = '{"rx_parity", 32'hA5090003, mkpay(11'd10, 11'd20, 9'd30) ^ 32'h20, 11'd10, 11'd20, 9'd14, 2'd3};
`endif
    vecs[6] = '{"rx_seq10", 32'hA50A0000, mkpay(11'd1, 11'd2, 9'd3), 11'd1, 11'd2, 9'd3, 2'd0};

    // Reset state
    step();
    step();
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", tx_data, 32'd0);
    check_opp("rst_opp", 11'd0, 11'd0, 9'd0, 2'd0, 1'b0);
    rst = 1'b0;
    step();

    // Basic TX with ready high: one-cycle latency, two-cycle packet
    tx_ready = 1'b1;
    tx_expect(11'd191, 11'd191, 9'd270, 2'd1);
    pulse_frame();
    check("tx_latency_valid", 32'(tx_valid), 32'd1);
    check("tx_hdr_basic", tx_data, 32'hA5000001);
    step();
    check("tx_pay_basic", tx_data, mkpay(11'd191, 11'd191, 9'd270));
    step();
    check("tx_pkt_len", 32'(tx_valid), 32'd0);
    tx_expect(11'd12, 11'd34, 9'd56, 2'd3);
    pulse_frame();
    check("tx_hdr_seq1", tx_data, mkhdr(8'd1, 2'd3));
    drain_tx();

    // Backpressure in HDR, then a frame start during PAY that must be ignored
    tx_ready = 1'b0;
    tx_expect(11'd400, 11'd401, 9'd359, 2'd2);
    pulse_frame();
    for (int i = 0; i < 5; i++) begin
      check("bp_hdr_valid", 32'(tx_valid), 32'd1);
      check("bp_hdr_hold", tx_data, mkhdr(8'd2, 2'd2));
      step();
    end
    tx_ready = 1'b1;
    check("bp_hdr_last", tx_data, mkhdr(8'd2, 2'd2));
    step();
    check("bp_pay", tx_data, mkpay(11'd400, 11'd401, 9'd359));
    pulse_frame();
    check("bp_pay_one_cycle", 32'(tx_valid), 32'd0);
    step();
    step();
    check("bp_no_extra_pkt", 32'(tx_valid), 32'd0);
    drain_tx();

    // RX vector table
    for (int i = 0; i < 7; i++) begin
      rx_word(vecs[i].hdr);
      rx_word(vecs[i].pay);
      $display("rx vec %s hdr=%h pay=%h", vecs[i].name, vecs[i].hdr, vecs[i].pay);
      check_opp(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].dir, vecs[i].stat, 1'b1);
    end

    // Gap abort: 64 idle cycles drops the header, 63 does not
    rx_word(32'hA50B0002);
    repeat (RX_GAP_CYCLES) step();
    rx_word(mkpay(11'd200, 11'd201, 9'd202));
    check_opp("rx_gap_abort", 11'd1, 11'd2, 9'd3, 2'd0, 1'b1);
    rx_word(32'hA50C0002);
    repeat (RX_GAP_CYCLES - 1) step();
    rx_word(mkpay(11'd200, 11'd201, 9'd202));
    check_opp("rx_gap_edge", 11'd200, 11'd201, 9'd202, 2'd2, 1'b1);

    // Link timeout on the 30th frame start without an accepted packet
    for (int k = 1; k <= TIMEOUT_FRAMES; k++) begin
      tx_expect(11'd7, 11'd8, 9'd9, 2'd2);
      pulse_frame();
      if (k >= TIMEOUT_FRAMES - 1) begin
        check("timeout_link", 32'(link_up), (k < TIMEOUT_FRAMES) ? 32'd1 : 32'd0);
      end
      step();
      step();
      step();
    end
    check_opp("timeout_hold", 11'd200, 11'd201, 9'd202, 2'd2, 1'b0);
    drain_tx();

    // Sequence wrap 255 -> 0, both accepted
    rx_word(32'hA5FF0001);
    rx_word(mkpay(11'd50, 11'd60, 9'd70));
    check_opp("rx_seq255", 11'd50, 11'd60, 9'd70, 2'd1, 1'b1);
    rx_word(32'hA5000002);
    rx_word(mkpay(11'd51, 11'd61, 9'd71));
    check_opp("rx_seq0_wrap", 11'd51, 11'd61, 9'd71, 2'd2, 1'b1);

    // Reset mid-packet drops valid on the next edge
    tx_ready = 1'b0;
    player_x = 11'd3;
    pulse_frame();
    check("rst_mid_pre", 32'(tx_valid), 32'd1);
    rst = 1'b1;
    step();
    check("rst_mid_valid", 32'(tx_valid), 32'd0);
    check_opp("rst_mid_opp", 11'd0, 11'd0, 9'd0, 2'd0, 1'b0);
    rst = 1'b0;
    step();
    check("tx_queue_empty", 32'(tx_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
